branch_resolution_queue: RTL

- Consumer side of the branch predictor. Records each prediction issued at fetch in an in-order queue.
- Each branch is resolved in order at execute. The block compares the actual outcome with the recorded prediction.
- It drives the predictor's training write port (enable, index, taken, jumped) and signals a mispredict that flushes fetch.
- It flushes its own wrong-path entries on a mispredict.
- It keeps saturating branch and mispredict statistics.

---
 rtl/bp_pkg.sv | 14 +
 rtl/bp_entry_fifo.sv | 43 ++++
 rtl/branch_resolution_queue.sv | 82 ++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor and its resolution queue.
package bp_pkg;
   localparam int LOWER = 5;

   localparam logic [1:0] STRONG_NT = 2'b00;
   localparam logic [1:0] WEAK_NT   = 2'b01;
   localparam logic [1:0] WEAK_T    = 2'b10;
   localparam logic [1:0] STRONG_T  = 2'b11;

   typedef struct packed {
      logic [LOWER-1:0] index;
      logic             taken;
   } bp_entry_t;
endpackage

// File: rtl/bp_entry_fifo.sv
// In-order storage of in-flight predictions; occupancy is tracked by count, not pointer compare.
module bp_entry_fifo import bp_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int W     = LOWER + 1,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic [W-1:0]  head_o,
   output logic [PW:0]   count_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [PW:0]   count_q;

   always_ff @(posedge clk) begin
      if (push_i) mem_q[tail_q] <= din_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         // Flush drops the popped entry and everything younger.
         head_q  <= head_q + 1'b1;
         tail_q  <= head_q + 1'b1;
         count_q <= '0;
      end else begin
         if (push_i) tail_q <= tail_q + 1'b1;
         if (pop_i)  head_q <= head_q + 1'b1;
         count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
      end
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;
endmodule

// File: rtl/branch_resolution_queue.sv
// Matches in-order resolutions against recorded predictions, trains the predictor and flags mispredicts.
module branch_resolution_queue import bp_pkg::*; #(
   parameter int LOWER = bp_pkg::LOWER,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pred_valid,
   input  logic [LOWER-1:0] pred_index,
   input  logic             pred_taken,
   output logic             pred_ready,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic             res_jump,
   output logic             upd_en,
   output logic [LOWER-1:0] upd_addr,
   output logic             upd_was_taken,
   output logic             upd_jumped,
   output logic             mispredict,
   output logic             res_err,
   output logic [CW-1:0]    count,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);
   logic [LOWER:0]   head;
   logic             do_res, wrong, flush, pop, push;
   logic             upd_en_q, was_q, jmp_q, mis_q, err_q;
   logic [LOWER-1:0] addr_q;
   logic [CNT_W-1:0] bcnt_q, mcnt_q;

   assign pred_ready = (count < CW'(DEPTH));
   assign do_res     = res_valid & (count != '0);
   assign wrong      = (res_taken | res_jump) != head[0];
   assign flush      = do_res & wrong;
   assign pop        = do_res & ~wrong;
   // A push alongside a mispredict is on the wrong path.
   assign push       = pred_valid & pred_ready & ~flush;

   bp_entry_fifo #(.DEPTH(DEPTH), .W(LOWER+1)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   ({pred_index, pred_taken}),
      .pop_i   (pop),
      .flush_i (flush),
      .head_o  (head),
      .count_o (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         upd_en_q <= 1'b0;
         addr_q   <= '0;
         was_q    <= 1'b0;
         jmp_q    <= 1'b0;
         mis_q    <= 1'b0;
         err_q    <= 1'b0;
         bcnt_q   <= '0;
         mcnt_q   <= '0;
      end else begin
         upd_en_q <= do_res;
         addr_q   <= do_res ? head[LOWER:1] : '0;
         was_q    <= do_res & res_taken;
         jmp_q    <= do_res & res_jump;
         mis_q    <= flush;
         err_q    <= err_q | (res_valid & (count == '0));
         if (do_res && bcnt_q != '1) bcnt_q <= bcnt_q + 1'b1;
         if (flush  && mcnt_q != '1) mcnt_q <= mcnt_q + 1'b1;
      end
   end

   assign upd_en        = upd_en_q;
   assign upd_addr      = addr_q;
   assign upd_was_taken = was_q;
   assign upd_jumped    = jmp_q;
   assign mispredict    = mis_q;
   assign res_err       = err_q;
   assign branch_cnt    = bcnt_q;
   assign mispred_cnt   = mcnt_q;
endmodule
